pcu_seq: RTL and testbench

PCU_SEQ -- requirements
Module: pcu_seq

---
 rtl/pcu_seq.sv | 119 +++++++++++
 tb/tb_pcu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcu_seq.sv
// PC unit sequencer: fetch/wait/issue/halt control, PC, retire count.
// Optional PCU_MISALIGN_TRAP_EN halts on a misaligned next PC.
module pcu_seq #(
  parameter int unsigned CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic [CPU_WIDTH-1:0] o_pcu_pc,
  output logic                 o_imem_req,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [31:0]          i_imem_rdata,
  output logic [31:0]          o_pcu_inst,
  output logic                 o_pcu_inst_valid,
  input  logic                 i_exu_done,
  input  logic [CPU_WIDTH-1:0] i_bru_next_pc,
  input  logic                 i_exu_ebreak,
  output logic                 o_pcu_commit,
  output logic [31:0]          o_pcu_icount,
`ifdef PCU_MISALIGN_TRAP_EN
  output logic                 o_pcu_misalign,
`endif
  output logic                 o_pcu_halt
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]           r_state;
  logic [CPU_WIDTH-1:0] r_pc;
  logic [31:0]          r_inst;
  logic                 r_commit;
  logic [31:0]          r_icount;
  logic                 w_misalign;
`ifdef PCU_MISALIGN_TRAP_EN
  logic                 r_misalign;
`endif

  // Misaligned target only matters for a normal (non-ebreak) retire;
  // ebreak keeps the PC so its next-PC is never loaded.
`ifdef PCU_MISALIGN_TRAP_EN
  assign w_misalign = ~i_exu_ebreak & (i_bru_next_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Sequencer state, PC, instruction latch and retire bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_inst   <= 32'h0;
      r_commit <= 1'b0;
      r_icount <= 32'h0;
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        FETCH: begin
          if (i_imem_gnt) begin
            if (i_imem_rvalid) begin
              r_inst  <= i_imem_rdata;
              r_state <= ISSUE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_imem_rvalid) begin
            r_inst  <= i_imem_rdata;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_exu_done) begin
            if (w_misalign) begin
              r_state <= HALT;
            end else begin
              r_commit <= 1'b1;
              r_icount <= r_icount + 32'd1;
              if (i_exu_ebreak) begin
                r_state <= HALT;
              end else begin
                r_pc    <= i_bru_next_pc;
                r_state <= FETCH;
              end
            end
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end

`ifdef PCU_MISALIGN_TRAP_EN
  // Sticky misalign flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misalign <= 1'b0;
    end else if (r_state == ISSUE && i_exu_done && w_misalign) begin
      r_misalign <= 1'b1;
    end
  end

  assign o_pcu_misalign = r_misalign;
`endif

  assign o_pcu_pc         = r_pc;
  assign o_pcu_inst       = r_inst;
  assign o_pcu_commit     = r_commit;
  assign o_pcu_icount     = r_icount;
  assign o_imem_req       = (r_state == FETCH);
  assign o_pcu_inst_valid = (r_state == ISSUE);
  assign o_pcu_halt       = (r_state == HALT);

endmodule

// File: tb/tb_pcu_seq.sv
// Directed bench for pcu_seq: fetch paths, retire, ebreak halt,
// reset mid-WAIT, icount wrap, misaligned next-PC handling.
module tb_pcu_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] o_pcu_pc;
  logic        o_imem_req;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pcu_inst;
  logic        o_pcu_inst_valid;
  logic        i_exu_done;
  logic [31:0] i_bru_next_pc;
  logic        i_exu_ebreak;
  logic        o_pcu_commit;
  logic [31:0] o_pcu_icount;
  logic        o_pcu_halt;
`ifdef PCU_MISALIGN_TRAP_EN
  logic        o_pcu_misalign;
`endif

  int vectors = 0;
  int errors  = 0;

  pcu_seq dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .o_pcu_pc         (o_pcu_pc),
    .o_imem_req       (o_imem_req),
    .i_imem_gnt       (i_imem_gnt),
    .i_imem_rvalid    (i_imem_rvalid),
    .i_imem_rdata     (i_imem_rdata),
    .o_pcu_inst       (o_pcu_inst),
    .o_pcu_inst_valid (o_pcu_inst_valid),
    .i_exu_done       (i_exu_done),
    .i_bru_next_pc    (i_bru_next_pc),
    .i_exu_ebreak     (i_exu_ebreak),
    .o_pcu_commit     (o_pcu_commit),
    .o_pcu_icount     (o_pcu_icount),
`ifdef PCU_MISALIGN_TRAP_EN
    .o_pcu_misalign   (o_pcu_misalign),
`endif
    .o_pcu_halt       (o_pcu_halt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_exu_done    = 1'b0;
    i_exu_ebreak  = 1'b0;
  endtask

  initial begin
    i_rst         = 1'b1;
    i_imem_rdata  = 32'h0;
    i_bru_next_pc = 32'h0;
    idle();

    // reset state
    tick();
    tick();
    check("rst_pc", o_pcu_pc, 32'h8000_0000);
    check("rst_inst", o_pcu_inst, 32'h0);
    check("rst_commit", 32'(o_pcu_commit), 32'd0);
    check("rst_icount", o_pcu_icount, 32'd0);
    check("rst_halt", 32'(o_pcu_halt), 32'd0);
    i_rst = 1'b0;
    #1;
    check("first_req", 32'(o_imem_req), 32'd1);

    // gnt and rvalid together: one-cycle fetch
    i_imem_gnt    = 1'b1;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h0000_0013;
    tick();
    idle();
    check("fast_valid", 32'(o_pcu_inst_valid), 32'd1);
    check("fast_inst", o_pcu_inst, 32'h0000_0013);
    check("fast_pc", o_pcu_pc, 32'h8000_0000);
    check("fast_req", 32'(o_imem_req), 32'd0);

    // retire to new PC
    i_exu_done    = 1'b1;
    i_bru_next_pc = 32'h8000_0100;
    tick();
    idle();
    check("ret_pc", o_pcu_pc, 32'h8000_0100);
    check("ret_commit", 32'(o_pcu_commit), 32'd1);
    check("ret_icount", o_pcu_icount, 32'd1);
    check("ret_req", 32'(o_imem_req), 32'd1);
    tick();
    check("ret_commit_pulse", 32'(o_pcu_commit), 32'd0);
    check("ret_refetch", 32'(o_imem_req), 32'd1);

    // gnt now, rvalid three cycles later; stray done ignored in WAIT
    i_imem_gnt = 1'b1;
    tick();
    idle();
    i_exu_done    = 1'b1;
    i_bru_next_pc = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      check("wait_req", 32'(o_imem_req), 32'd0);
      check("wait_valid", 32'(o_pcu_inst_valid), 32'd0);
      tick();
    end
    check("wait_req3", 32'(o_imem_req), 32'd0);
    check("wait_pc", o_pcu_pc, 32'h8000_0100);
    check("wait_icount", o_pcu_icount, 32'd1);
    idle();
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h0010_0093;
    tick();
    idle();
    check("slow_valid", 32'(o_pcu_inst_valid), 32'd1);
    check("slow_inst", o_pcu_inst, 32'h0010_0093);

    // rvalid during ISSUE must not disturb the latch
    i_imem_rvalid = 1'b1;
    i_imem_gnt    = 1'b1;
    i_imem_rdata  = 32'hDEAD_BEEF;
    tick();
    idle();
    check("issue_hold", o_pcu_inst, 32'h0010_0093);
    check("issue_stay", 32'(o_pcu_inst_valid), 32'd1);

    // ebreak retire halts, PC unchanged
    i_exu_done    = 1'b1;
    i_exu_ebreak  = 1'b1;
    i_bru_next_pc = 32'h9000_0000;
    tick();
    idle();
    check("ebk_halt", 32'(o_pcu_halt), 32'd1);
    check("ebk_pc", o_pcu_pc, 32'h8000_0100);
    check("ebk_icount", o_pcu_icount, 32'd2);
    check("ebk_commit", 32'(o_pcu_commit), 32'd1);

    // halt absorbs all activity
    i_imem_gnt    = 1'b1;
    i_imem_rvalid = 1'b1;
    i_exu_done    = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    idle();
    check("hlt_halt", 32'(o_pcu_halt), 32'd1);
    check("hlt_req", 32'(o_imem_req), 32'd0);
    check("hlt_icount", o_pcu_icount, 32'd2);
    check("hlt_pc", o_pcu_pc, 32'h8000_0100);
    check("hlt_commit", 32'(o_pcu_commit), 32'd0);

    // reset recovers
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rec_pc", o_pcu_pc, 32'h8000_0000);
    check("rec_halt", 32'(o_pcu_halt), 32'd0);
    check("rec_icount", o_pcu_icount, 32'd0);
    check("rec_req", 32'(o_imem_req), 32'd1);

    // one retire, then reset in the middle of WAIT
    i_imem_gnt    = 1'b1;
    i_imem_rvalid = 1'b1;
    tick();
    idle();
    i_exu_done    = 1'b1;
    i_bru_next_pc = 32'h8000_0040;
    tick();
    idle();
    check("mw_icount_pre", o_pcu_icount, 32'd1);
    i_imem_gnt = 1'b1;
    tick();
    idle();
    check("mw_in_wait", 32'(o_imem_req), 32'd0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("mw_req", 32'(o_imem_req), 32'd1);
    check("mw_pc", o_pcu_pc, 32'h8000_0000);
    check("mw_icount", o_pcu_icount, 32'd0);
    check("mw_inst", o_pcu_inst, 32'h0);

    // icount wrap
    force dut.r_icount = 32'hFFFF_FFFE;
    #1;
    release dut.r_icount;
    i_imem_gnt    = 1'b1;
    i_imem_rvalid = 1'b1;
    tick();
    idle();
    i_exu_done    = 1'b1;
    i_bru_next_pc = 32'h8000_0004;
    tick();
    idle();
    check("wrap_ff", o_pcu_icount, 32'hFFFF_FFFF);
    i_imem_gnt    = 1'b1;
    i_imem_rvalid = 1'b1;
    tick();
    idle();
    i_exu_done    = 1'b1;
    i_bru_next_pc = 32'h8000_0008;
    tick();
    idle();
    check("wrap_zero", o_pcu_icount, 32'd0);
    check("wrap_commit", 32'(o_pcu_commit), 32'd1);
    check("wrap_pc", o_pcu_pc, 32'h8000_0008);

    // misaligned next PC
    i_imem_gnt    = 1'b1;
    i_imem_rvalid = 1'b1;
    tick();
    idle();
    i_exu_done    = 1'b1;
    i_bru_next_pc = 32'h8000_0102;
    tick();
    idle();
`ifdef PCU_MISALIGN_TRAP_EN
    check("mis_flag", 32'(o_pcu_misalign), 32'd1);
    check("mis_halt", 32'(o_pcu_halt), 32'd1);
    check("mis_pc", o_pcu_pc, 32'h8000_0008);
    check("mis_commit", 32'(o_pcu_commit), 32'd0);
    check("mis_icount", o_pcu_icount, 32'd0);
`else
    check("mis_pc", o_pcu_pc, 32'h8000_0102);
    check("mis_commit", 32'(o_pcu_commit), 32'd1);
    check("mis_icount", o_pcu_icount, 32'd1);
    check("mis_halt", 32'(o_pcu_halt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
